l2_port_arbiter: RTL and testbench

- Shares the single L2 request port between three requesters: I-cache demand fill, D-cache demand fill, and the next-line prefetcher.
- Demand traffic has priority over prefetch. I and D demand alternate round-robin. A starvation counter guarantees the prefetcher eventually wins.
- Exactly one L2 transaction is outstanding at a time. The response is returned to the winner with a one-cycle done pulse.

---
 rtl/l2_arb_pkg.sv | 19 +
 rtl/l2_arb_pick.sv | 31 +++
 rtl/l2_port_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_l2_port_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_arb_pkg.sv
// Shared types and constants for the L2 port arbiter slice.
package l2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    G_NONE = 2'd0,
    G_IC   = 2'd1,
    G_DC   = 2'd2,
    G_PF   = 2'd3
  } grant_t;

  localparam int LINE_OFFSET_W = 5;

endpackage

// File: rtl/l2_arb_pick.sv
// Combinational winner select: starved prefetch, then round-robin demand, then prefetch.
module l2_arb_pick
  import l2_arb_pkg::*;
(
  input  logic   ic_req,
  input  logic   dc_req,
  input  logic   pf_req,
  input  logic   pf_starved,
  input  grant_t rr_ptr,
  output grant_t winner
);

  // Priority chain for the IDLE-state grant decision
  always_comb begin
    winner = G_NONE;
    if (pf_req && pf_starved) begin
      winner = G_PF;
    end else if (ic_req && dc_req) begin
      winner = (rr_ptr == G_DC) ? G_DC : G_IC;
    end else if (ic_req) begin
      winner = G_IC;
    end else if (dc_req) begin
      winner = G_DC;
    end else if (pf_req) begin
      winner = G_PF;
    end else begin
      winner = G_NONE;
    end
  end

endmodule

// File: rtl/l2_port_arbiter.sv
// Shares one L2 request port between I-cache, D-cache and prefetcher, one transaction at a time.
// Optional watchdog on the L2 response is enabled by defining L2_TIMEOUT_EN.
module l2_port_arbiter
  import l2_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 256,
  parameter int PF_STARVE_MAX  = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_done,
  input  logic              dc_req,
  input  logic [ADDR_W-1:0] dc_addr,
  output logic              dc_done,
  input  logic              pf_req,
  input  logic [ADDR_W-1:0] pf_addr,
  output logic              pf_done,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic [1:0]        grant_id,
  output logic [ADDR_W-1:0] l2_addr,
  output logic              l2_request,
  input  logic [DATA_W-1:0] l2_data,
  input  logic              l2_done
);

  localparam int STARVE_W = $clog2(PF_STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(PF_STARVE_MAX);
  localparam logic [ADDR_W-1:0] LINE_MASK =
    {{(ADDR_W-LINE_OFFSET_W){1'b1}}, {LINE_OFFSET_W{1'b0}}};

  arb_state_t           state_q, state_d;
  grant_t               grant_q, grant_d;
  grant_t               rr_ptr_q, rr_ptr_d;
  grant_t               winner_s;
  logic [STARVE_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic [ADDR_W-1:0]    l2_addr_q, l2_addr_d;
  logic [ADDR_W-1:0]    sel_addr_s;
  logic                 l2_request_q, l2_request_d;
  logic [DATA_W-1:0]    resp_data_q, resp_data_d;
  logic                 resp_err_q, resp_err_d;
  logic                 ic_done_q, ic_done_d;
  logic                 dc_done_q, dc_done_d;
  logic                 pf_done_q, pf_done_d;

`ifdef L2_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             expire_s;
  // Expiry is flagged in the TIMEOUT_CYCLES-th BUSY cycle; the timer starts at zero
  assign expire_s = (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT_CYCLES != 32'sd0);
`endif

  l2_arb_pick u_pick (
    .ic_req     (ic_req),
    .dc_req     (dc_req),
    .pf_req     (pf_req),
    .pf_starved (starve_cnt_q == STARVE_LIM),
    .rr_ptr     (rr_ptr_q),
    .winner     (winner_s)
  );

  // Address of the current winner
  always_comb begin
    case (winner_s)
      G_IC:    sel_addr_s = ic_addr;
      G_DC:    sel_addr_s = dc_addr;
      G_PF:    sel_addr_s = pf_addr;
      default: sel_addr_s = {ADDR_W{1'b0}};
    endcase
  end

  // FSM next state plus grant bookkeeping and response capture
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    starve_cnt_d = starve_cnt_q;
    l2_addr_d    = l2_addr_q;
    l2_request_d = l2_request_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    ic_done_d    = 1'b0;
    dc_done_d    = 1'b0;
    pf_done_d    = 1'b0;
`ifdef L2_TIMEOUT_EN
    timer_d      = timer_q;
`endif
    case (state_q)
      IDLE: begin
        if (winner_s != G_NONE) begin
          l2_addr_d    = sel_addr_s & LINE_MASK;
          l2_request_d = 1'b1;
          grant_d      = winner_s;
          state_d      = BUSY;
`ifdef L2_TIMEOUT_EN
          timer_d      = {TMR_W{1'b0}};
`endif
          if (winner_s == G_IC) begin
            rr_ptr_d = G_DC;
          end else if (winner_s == G_DC) begin
            rr_ptr_d = G_IC;
          end else begin
            rr_ptr_d = rr_ptr_q;
          end
          // Any prefetch grant or an absent prefetch resets the starvation run
          if ((winner_s == G_PF) || !pf_req) begin
            starve_cnt_d = {STARVE_W{1'b0}};
          end else if (starve_cnt_q != STARVE_LIM) begin
            starve_cnt_d = starve_cnt_q + STARVE_W'(1'b1);
          end else begin
            starve_cnt_d = starve_cnt_q;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (l2_done) begin
          l2_request_d = 1'b0;
          resp_data_d  = l2_data;
          resp_err_d   = 1'b0;
          ic_done_d    = (grant_q == G_IC);
          dc_done_d    = (grant_q == G_DC);
          pf_done_d    = (grant_q == G_PF);
          state_d      = RESP;
`ifdef L2_TIMEOUT_EN
        end else if (expire_s) begin
          l2_request_d = 1'b0;
          resp_err_d   = 1'b1;
          ic_done_d    = (grant_q == G_IC);
          dc_done_d    = (grant_q == G_DC);
          pf_done_d    = (grant_q == G_PF);
          state_d      = RESP;
        end else begin
          timer_d = timer_q + TMR_W'(1'b1);
        end
`else
        end else begin
          state_d = BUSY;
        end
`endif
      end
      RESP: begin
        grant_d = G_NONE;
        state_d = IDLE;
      end
      default: begin
        grant_d      = G_NONE;
        l2_request_d = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= G_NONE;
      rr_ptr_q     <= G_IC;
      starve_cnt_q <= {STARVE_W{1'b0}};
      l2_addr_q    <= {ADDR_W{1'b0}};
      l2_request_q <= 1'b0;
      resp_data_q  <= {DATA_W{1'b0}};
      resp_err_q   <= 1'b0;
      ic_done_q    <= 1'b0;
      dc_done_q    <= 1'b0;
      pf_done_q    <= 1'b0;
`ifdef L2_TIMEOUT_EN
      timer_q      <= {TMR_W{1'b0}};
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      starve_cnt_q <= starve_cnt_d;
      l2_addr_q    <= l2_addr_d;
      l2_request_q <= l2_request_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      ic_done_q    <= ic_done_d;
      dc_done_q    <= dc_done_d;
      pf_done_q    <= pf_done_d;
`ifdef L2_TIMEOUT_EN
      timer_q      <= timer_d;
`endif
    end
  end

  assign ic_done    = ic_done_q;
  assign dc_done    = dc_done_q;
  assign pf_done    = pf_done_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign grant_id   = grant_q;
  assign l2_addr    = l2_addr_q;
  assign l2_request = l2_request_q;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Randomized self-checking bench for l2_port_arbiter against a request-set reference model.
module tb_l2_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 256;
  localparam int SMAX = 4;
  localparam int TO   = 8;
  localparam logic [AW-1:0] LINE_MASK = 32'hFFFF_FFE0;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ic_req = 1'b0, dc_req = 1'b0, pf_req = 1'b0;
  logic [AW-1:0] ic_addr = '0, dc_addr = '0, pf_addr = '0;
  logic          ic_done, dc_done, pf_done;
  logic [DW-1:0] resp_data;
  logic          resp_err;
  logic [1:0]    grant_id;
  logic [AW-1:0] l2_addr;
  logic          l2_request;
  logic [DW-1:0] l2_data = '0;
  logic          l2_done = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model: pending requesters (1 IC, 2 DC, 3 PF), fairness state, last results
  bit            pend [1:3];
  logic [AW-1:0] paddr [1:3];
  int            hold;
  int            m_rr;
  int            m_starve;
  logic [DW-1:0] m_data;
  logic [AW-1:0] m_addr;

  l2_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .PF_STARVE_MAX(SMAX), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done),
    .dc_req(dc_req), .dc_addr(dc_addr), .dc_done(dc_done),
    .pf_req(pf_req), .pf_addr(pf_addr), .pf_done(pf_done),
    .resp_data(resp_data), .resp_err(resp_err), .grant_id(grant_id),
    .l2_addr(l2_addr), .l2_request(l2_request),
    .l2_data(l2_data), .l2_done(l2_done)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // A requester just served is kept low for one extra cycle (hold) before it may re-request
  function automatic bit visible(input int k);
    return pend[k] && (hold != k);
  endfunction

  function automatic int model_pick();
    if (visible(3) && m_starve == SMAX) return 3;
    if (visible(1) && visible(2)) return m_rr;
    if (visible(1)) return 1;
    if (visible(2)) return 2;
    if (visible(3)) return 3;
    return 0;
  endfunction

  task automatic drive_reqs();
    ic_req = visible(1); ic_addr = paddr[1];
    dc_req = visible(2); dc_addr = paddr[2];
    pf_req = visible(3); pf_addr = paddr[3];
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int k = 1; k <= 3; k++) pend[k] = 1'b0;
    hold = 0;
    drive_reqs();
    l2_done = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_rr = 1; m_starve = 0; m_data = '0; m_addr = '0;
  endtask

  // One full arbitration + L2 transaction; gid is the grant_id observed on the port
  task automatic serve(input int lat, output int gid);
    int            who;
    bit            pf_vis;
    logic [DW-1:0] d;
    logic [AW-1:0] ea;
    logic [2:0]    exp_done;
    who = 0;
    gid = 0;
    for (int t = 0; t < 3 && who == 0; t++) begin
      drive_reqs();
      who = model_pick();
      if (who == 0) begin
        @(negedge clk);
        hold = 0;
      end
    end
    if (who == 0) begin
      checks++; errors++;
      $display("FAIL serve_start: got no visible request, expected at least one");
      return;
    end
    ea = paddr[who] & LINE_MASK;
    d = rand_line();
    pf_vis = visible(3);
    @(posedge clk);
    @(negedge clk);
    hold = 0;
    drive_reqs();
    gid = int'(grant_id);
    checks++;
    if (grant_id !== 2'(who)) begin
      errors++; $display("FAIL grant_id: got %0d, expected %0d", grant_id, who);
    end
    checks++;
    if (l2_request !== 1'b1) begin
      errors++; $display("FAIL l2_request_rise: got %b, expected 1", l2_request);
    end
    checks++;
    if (l2_addr !== ea) begin
      errors++; $display("FAIL l2_addr: got %h, expected %h", l2_addr, ea);
    end
    if (who == 1) m_rr = 2;
    else if (who == 2) m_rr = 1;
    if (who == 3 || !pf_vis) m_starve = 0;
    else if (m_starve < SMAX) m_starve++;
    m_addr = ea;
    repeat (lat) begin
      @(negedge clk);
      checks++;
      if ({ic_done, dc_done, pf_done} !== 3'b000 || l2_request !== 1'b1 || grant_id !== 2'(who)) begin
        errors++;
        $display("FAIL busy_hold: got done=%b req=%b gid=%0d, expected done=000 req=1 gid=%0d",
                 {ic_done, dc_done, pf_done}, l2_request, grant_id, who);
      end
    end
    l2_data = d;
    l2_done = 1'b1;
    @(posedge clk);
    #1 l2_done = 1'b0;
    l2_data = rand_line();
    @(negedge clk);
    exp_done = (who == 1) ? 3'b100 : (who == 2) ? 3'b010 : 3'b001;
    checks++;
    if ({ic_done, dc_done, pf_done} !== exp_done) begin
      errors++; $display("FAIL done_pulse: got %b, expected %b", {ic_done, dc_done, pf_done}, exp_done);
    end
    checks++;
    if (resp_data !== d) begin
      errors++; $display("FAIL resp_data: got %h, expected %h", resp_data, d);
    end
    checks++;
    if (resp_err !== 1'b0 || l2_request !== 1'b0) begin
      errors++; $display("FAIL resp_flags: got err=%b req=%b, expected err=0 req=0", resp_err, l2_request);
    end
    m_data = d;
    pend[who] = 1'b0;
    hold = who;
    drive_reqs();
    @(negedge clk);
    checks++;
    if ({ic_done, dc_done, pf_done} !== 3'b000 || grant_id !== 2'd0) begin
      errors++; $display("FAIL resp_exit: got done=%b gid=%0d, expected done=000 gid=0",
                         {ic_done, dc_done, pf_done}, grant_id);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({l2_request, ic_done, dc_done, pf_done, resp_err} !== 5'b0 || grant_id !== 2'd0 ||
        l2_addr !== '0 || resp_data !== '0) begin
      errors++; $display("FAIL reset_state: got req=%b gid=%0d addr=%h data=%h, expected all zero",
                         l2_request, grant_id, l2_addr, resp_data);
    end
  endtask

  task automatic test_ic_single();
    int gid;
    pend[1] = 1'b1; paddr[1] = 32'h0000_1234;
    serve(3, gid);
    checks++;
    if (m_addr !== 32'h0000_1220 || gid != 1) begin
      errors++; $display("FAIL ic_single: got gid=%0d addr=%h, expected gid=1 addr=00001220", gid, m_addr);
    end
  endtask

  task automatic test_idle_done();
    l2_data = rand_line();
    l2_done = 1'b1;
    @(posedge clk);
    #1 l2_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (resp_data !== m_data || l2_addr !== m_addr || grant_id !== 2'd0 || l2_request !== 1'b0 ||
          {ic_done, dc_done, pf_done, resp_err} !== 4'b0) begin
        errors++; $display("FAIL idle_done: got data=%h addr=%h gid=%0d req=%b, expected data=%h addr=%h gid=0 req=0",
                           resp_data, l2_addr, grant_id, l2_request, m_data, m_addr);
      end
    end
  endtask

  task automatic test_round_robin();
    int gid;
    int rr_exp [4] = '{1, 2, 1, 2};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      for (int k = 1; k <= 2; k++) if (!pend[k]) begin pend[k] = 1'b1; paddr[k] = $urandom(); end
      serve(1, gid);
      checks++;
      if (gid != rr_exp[i]) begin
        errors++; $display("FAIL rr_order[%0d]: got %0d, expected %0d", i, gid, rr_exp[i]);
      end
    end
  endtask

  task automatic test_starvation();
    int gid;
    int st_exp [11] = '{1, 2, 1, 2, 3, 1, 2, 1, 2, 1, 3};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      for (int k = 1; k <= 3; k++) if (!pend[k]) begin pend[k] = 1'b1; paddr[k] = $urandom(); end
      serve($urandom_range(0, 2), gid);
      checks++;
      if (gid != st_exp[i]) begin
        errors++; $display("FAIL starve_order[%0d]: got %0d, expected %0d", i, gid, st_exp[i]);
      end
    end
  endtask

  task automatic test_reset_busy();
    do_reset();
    pend[1] = 1'b1; paddr[1] = $urandom();
    drive_reqs();
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (l2_request !== 1'b1) begin
      errors++; $display("FAIL rb_busy: got req=%b, expected 1", l2_request);
    end
    reset = 1'b1;
    pend[1] = 1'b0;
    drive_reqs();
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (l2_request !== 1'b0 || grant_id !== 2'd0) begin
      errors++; $display("FAIL rb_drop: got req=%b gid=%0d, expected req=0 gid=0", l2_request, grant_id);
    end
    @(negedge clk);
    l2_data = rand_line();
    l2_done = 1'b1;
    @(posedge clk);
    #1 l2_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({ic_done, dc_done, pf_done} !== 3'b000 || grant_id !== 2'd0 || l2_request !== 1'b0 ||
          resp_data !== '0) begin
        errors++; $display("FAIL rb_late_done: got done=%b gid=%0d req=%b, expected done=000 gid=0 req=0",
                           {ic_done, dc_done, pf_done}, grant_id, l2_request);
      end
    end
    m_rr = 1; m_starve = 0; m_data = '0; m_addr = '0;
  endtask

  task automatic test_random();
    int gid;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      for (int k = 1; k <= 3; k++)
        if (!pend[k] && $urandom_range(0, 1) == 1) begin pend[k] = 1'b1; paddr[k] = $urandom(); end
      if (!pend[1] && !pend[2] && !pend[3]) begin
        gid = $urandom_range(1, 3);
        pend[gid] = 1'b1; paddr[gid] = $urandom();
      end
      serve($urandom_range(0, 4), gid);
    end
  endtask

`ifdef L2_TIMEOUT_EN
  task automatic test_timeout();
    int gid;
    int cnt;
    do_reset();
    pend[3] = 1'b1; paddr[3] = $urandom();
    drive_reqs();
    @(posedge clk);
    @(negedge clk);
    cnt = 0;
    while (pf_done !== 1'b1 && cnt < 64) begin
      @(negedge clk);
      cnt++;
    end
    checks++;
    if (cnt != TO || resp_err !== 1'b1 || l2_request !== 1'b0 || resp_data !== m_data) begin
      errors++; $display("FAIL timeout: got cycles=%0d err=%b req=%b, expected cycles=%0d err=1 req=0",
                         cnt, resp_err, l2_request, TO);
    end
    m_starve = 0;
    pend[3] = 1'b0; hold = 3;
    drive_reqs();
    @(negedge clk);
    pend[2] = 1'b1; paddr[2] = $urandom();
    serve(2, gid);
  endtask
`endif

  initial begin
    for (int k = 1; k <= 3; k++) begin pend[k] = 1'b0; paddr[k] = '0; end
    hold = 0;
    test_reset();
    test_ic_single();
    test_idle_done();
    test_round_robin();
    test_starvation();
    test_reset_busy();
    test_random();
`ifdef L2_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
